// File: rtl/sha256_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sha256_sequencer: nonce-sweep job FSM driving a SHA-256 round core       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sha256_sequencer #(
  parameter int NONCE_LSB = 384
) (
  input  logic         clk_fast,
  input  logic         rst,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [511:0] msg_in,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_count,
  input  logic         abort,
  input  logic         found,
  output logic [511:0] message,
  output logic [6:0]   round,
  output logic         rotate_W,
  output logic         start,
  output logic         round_enable,
  output logic         enable_last_addition,
  output logic         idle_rst,
  output logic [31:0]  K,
  output logic         busy,
  output logic         done,
  output logic         hit,
  output logic [31:0]  hit_nonce
);

  localparam logic [31:0] c_k_rom [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PRIME = 3'd2,
    S_ROUND = 3'd3,
    S_FINAL = 3'd4,
    S_CHECK = 3'd5
  } state_t;

  state_t       r_state;
  logic [511:0] r_message;
  logic [31:0]  r_nonce;
  logic [31:0]  r_remaining;
  logic [6:0]   r_round;
  logic [31:0]  r_k;
  logic         r_job_ready, r_idle_rst, r_start, r_rotate_w, r_round_enable, r_last_add;
  logic         r_busy, r_done, r_hit;
  logic [31:0]  r_hit_nonce;

  logic [31:0]  w_nonce_inc;
  logic [511:0] w_msg_load;
  logic [511:0] w_msg_next;

  // Nonce field is spliced into the template both at accept and on each increment.
  always_comb begin
    w_nonce_inc = r_nonce + 32'd1;
    w_msg_load = msg_in;
    w_msg_load[NONCE_LSB +: 32] = nonce_start;
    w_msg_next = r_message;
    w_msg_next[NONCE_LSB +: 32] = w_nonce_inc;
  end

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_message      <= '0;
      r_nonce        <= '0;
      r_remaining    <= '0;
      r_round        <= '0;
      r_k            <= '0;
      r_job_ready    <= 1'b1;
      r_idle_rst     <= 1'b1;
      r_start        <= 1'b0;
      r_rotate_w     <= 1'b0;
      r_round_enable <= 1'b0;
      r_last_add     <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_hit          <= 1'b0;
      r_hit_nonce    <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (job_valid) begin
          r_message   <= w_msg_load;
          r_nonce     <= nonce_start;
          r_remaining <= nonce_count;
          r_hit       <= 1'b0;
          r_hit_nonce <= '0;
          if (nonce_count == 32'd0) begin
            r_done <= 1'b1;
          end else begin
            r_state     <= S_LOAD;
            r_job_ready <= 1'b0;
            r_idle_rst  <= 1'b0;
            r_start     <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
      end else if (abort) begin
        r_state        <= S_IDLE;
        r_job_ready    <= 1'b1;
        r_idle_rst     <= 1'b1;
        r_start        <= 1'b0;
        r_rotate_w     <= 1'b0;
        r_round_enable <= 1'b0;
        r_last_add     <= 1'b0;
        r_round        <= '0;
        r_k            <= '0;
        r_busy         <= 1'b0;
        r_done         <= 1'b1;
        r_hit          <= 1'b0;
      end else begin
        case (r_state)
          S_LOAD: begin
            r_state    <= S_PRIME;
            r_start    <= 1'b0;
            r_rotate_w <= 1'b1;
          end
          S_PRIME: begin
            r_state        <= S_ROUND;
            r_round_enable <= 1'b1;
            r_round        <= 7'd0;
            r_k            <= c_k_rom[0];
          end
          S_ROUND: begin
            if (r_round == 7'd63) begin
              r_state        <= S_FINAL;
              r_round_enable <= 1'b0;
              r_rotate_w     <= 1'b0;
              r_last_add     <= 1'b1;
              r_round        <= 7'd64;
              r_k            <= '0;
            end else begin
              r_round <= r_round + 7'd1;
              r_k     <= c_k_rom[r_round[5:0] + 6'd1];
            end
          end
          S_FINAL: begin
            r_state    <= S_CHECK;
            r_last_add <= 1'b0;
            r_idle_rst <= 1'b1;
          end
          S_CHECK: begin
            r_round <= '0;
            if (found || r_remaining == 32'd1) begin
              r_state     <= S_IDLE;
              r_job_ready <= 1'b1;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_hit       <= found;
              if (found) r_hit_nonce <= r_nonce;
            end else begin
              r_state     <= S_LOAD;
              r_idle_rst  <= 1'b0;
              r_start     <= 1'b1;
              r_nonce     <= w_nonce_inc;
              r_message   <= w_msg_next;
              r_remaining <= r_remaining - 32'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign job_ready            = r_job_ready;
  assign message              = r_message;
  assign round                = r_round;
  assign rotate_W             = r_rotate_w;
  assign start                = r_start;
  assign round_enable         = r_round_enable;
  assign enable_last_addition = r_last_add;
  assign idle_rst             = r_idle_rst;
  assign K                    = r_k;
  assign busy                 = r_busy;
  assign done                 = r_done;
  assign hit                  = r_hit;
  assign hit_nonce            = r_hit_nonce;

endmodule
`default_nettype wire

// File: tb/tb_sha256_sequencer.sv
`default_nettype none
// Directed bench for sha256_sequencer: cycle-exact control timing, nonce sweep, abort and reset.
module tb_sha256_sequencer;

  logic         clk_fast = 1'b0;
  logic         rst = 1'b0;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic [511:0] msg_in = '0;
  logic [31:0]  nonce_start = '0;
  logic [31:0]  nonce_count = '0;
  logic         abort = 1'b0;
  logic         found = 1'b0;
  logic [511:0] message;
  logic [6:0]   round;
  logic         rotate_W, start, round_enable, enable_last_addition, idle_rst;
  logic [31:0]  K;
  logic         busy, done, hit;
  logic [31:0]  hit_nonce;

  int n_vec = 0;
  int n_err = 0;

  logic [511:0] tmpl = {16{32'hDEADBEEF}};
  logic [14:0]  ctl;
  assign ctl = {job_ready, busy, done, idle_rst, start, rotate_W, round_enable, enable_last_addition, round};

  sha256_sequencer #(.NONCE_LSB(384)) dut (
    .clk_fast(clk_fast), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .msg_in(msg_in), .nonce_start(nonce_start), .nonce_count(nonce_count),
    .abort(abort), .found(found), .message(message), .round(round),
    .rotate_W(rotate_W), .start(start), .round_enable(round_enable),
    .enable_last_addition(enable_last_addition), .idle_rst(idle_rst), .K(K),
    .busy(busy), .done(done), .hit(hit), .hit_nonce(hit_nonce)
  );

  always #5 clk_fast = ~clk_fast;

  task automatic step();
    @(posedge clk_fast);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic accept(input logic [511:0] m, input logic [31:0] ns, input logic [31:0] nc);
    job_valid = 1'b1; msg_in = m; nonce_start = ns; nonce_count = nc;
    step();
    job_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1;
    n_vec++; if (ctl !== {1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 7'd0}) begin n_err++; $display("FAIL reset_ctl: got %h want %h", ctl, {1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 7'd0}); end
    n_vec++; if ({K, hit_nonce, hit} !== 65'd0) begin n_err++; $display("FAIL reset_k_hit: got K=%h hn=%h hit=%b want zeros", K, hit_nonce, hit); end
    n_vec++; if (message !== 512'd0) begin n_err++; $display("FAIL reset_msg: got %h want 0", message); end
    steps(2);
    rst = 1'b0;
    step();
    n_vec++; if (ctl !== {1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 7'd0}) begin n_err++; $display("FAIL reset_release: got %h want %h", ctl, {1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 7'd0}); end
  endtask

  task automatic test_abc();
    logic [511:0] m, expm;
    logic [14:0]  expv;
    logic [31:0]  expk;
    logic [6:0]   rnd;
    m = {32'h61626380, 416'h0, 64'h18};
    expm = m; expm[415:384] = 32'h12345678;
    accept(m, 32'h12345678, 32'd1);
    for (int c = 1; c <= 69; c++) begin
      found = (c >= 3 && c <= 67);
      rnd = (c >= 3 && c <= 66) ? 7'(c - 3) : ((c == 67 || c == 68) ? 7'd64 : 7'd0);
      expv = {c == 69, c <= 68, c == 69, c >= 68, c == 1, c >= 2 && c <= 66, c >= 3 && c <= 66, c == 67, rnd};
      n_vec++; if (ctl !== expv) begin n_err++; $display("FAIL abc_ctl cycle %0d: got %h want %h", c, ctl, expv); end
      if (c <= 4 || c >= 66) begin
        expk = (c == 3) ? 32'h428a2f98 : (c == 4) ? 32'h71374491 : (c == 66) ? 32'hc67178f2 : 32'h0;
        n_vec++; if (K !== expk) begin n_err++; $display("FAIL abc_K cycle %0d: got %h want %h", c, K, expk); end
      end
      if (c == 1 || c == 68) begin
        n_vec++; if (message !== expm) begin n_err++; $display("FAIL abc_msg cycle %0d: got %h want %h", c, message, expm); end
      end
      if (c < 69) step();
    end
    found = 1'b0;
    n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL abc_hit: got %b want 0", hit); end
  endtask

  task automatic test_wrap();
    logic [511:0] expm;
    logic [31:0]  seq;
    int p, k;
    accept(tmpl, 32'hFFFFFFFE, 32'd5);
    for (int c = 1; c <= 205; c++) begin
      found = (c == 204);
      p = (c - 1) % 68 + 1;
      k = (c - 1) / 68;
      seq = (k == 0) ? 32'hFFFFFFFE : (k == 1) ? 32'hFFFFFFFF : 32'h00000000;
      if (c <= 204 && p == 1) begin
        expm = tmpl; expm[415:384] = seq;
        n_vec++; if (message !== expm) begin n_err++; $display("FAIL wrap_msg nonce %0d: got %h want %h", k, message[415:384], seq); end
        n_vec++; if ({start, done} !== 2'b10) begin n_err++; $display("FAIL wrap_load nonce %0d: got start,done=%b want 10", k, {start, done}); end
      end
      if (c <= 204 && p == 68) begin
        n_vec++; if ({message[415:384], round, done} !== {seq, 7'd64, 1'b0}) begin n_err++; $display("FAIL wrap_check nonce %0d: got %h/%0d/%b want %h/64/0", k, message[415:384], round, done, seq); end
      end
      if (c == 205) begin
        n_vec++; if ({done, hit, job_ready, hit_nonce} !== {3'b111, 32'h0}) begin n_err++; $display("FAIL wrap_end: got d,h,r=%b hn=%h want 111 0", {done, hit, job_ready}, hit_nonce); end
      end
      if (c < 205) step();
    end
    found = 1'b0;
    steps(3);
    n_vec++; if ({done, hit, hit_nonce} !== {2'b01, 32'h0}) begin n_err++; $display("FAIL wrap_hold: got d,h=%b hn=%h want 01 0", {done, hit}, hit_nonce); end
  endtask

  task automatic test_zero_count();
    accept(tmpl, 32'hAAAA5555, 32'd0);
    n_vec++; if (ctl !== {1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 7'd0}) begin n_err++; $display("FAIL zero_ctl: got %h want %h", ctl, {1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 7'd0}); end
    n_vec++; if ({hit, hit_nonce} !== 33'd0) begin n_err++; $display("FAIL zero_hit: got hit=%b hn=%h want 0 0", hit, hit_nonce); end
    step();
    n_vec++; if ({done, start, busy} !== 3'b000) begin n_err++; $display("FAIL zero_after: got d,s,b=%b want 000", {done, start, busy}); end
  endtask

  task automatic test_abort();
    accept(tmpl, 32'h00000100, 32'd3);
    steps(32);
    n_vec++; if ({round, K, round_enable} !== {7'd30, 32'h06ca6351, 1'b1}) begin n_err++; $display("FAIL abort_t30: got %0d %h %b want 30 06ca6351 1", round, K, round_enable); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_vec++; if (ctl !== {1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 7'd0}) begin n_err++; $display("FAIL abort_idle: got %h want %h", ctl, {1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 7'd0}); end
    n_vec++; if ({hit, K} !== 33'd0) begin n_err++; $display("FAIL abort_hitk: got hit=%b K=%h want 0 0", hit, K); end
    step();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_pulse: got done=%b want 0", done); end
    // Accept together with abort in IDLE; the job must still run and hit.
    abort = 1'b1;
    accept(tmpl, 32'h00000042, 32'd1);
    abort = 1'b0;
    n_vec++; if ({start, busy} !== 2'b11) begin n_err++; $display("FAIL abort_idle_accept: got s,b=%b want 11", {start, busy}); end
    steps(67);
    found = 1'b1;
    n_vec++; if ({round, idle_rst} !== {7'd64, 1'b1}) begin n_err++; $display("FAIL rerun_check: got %0d %b want 64 1", round, idle_rst); end
    step();
    found = 1'b0;
    n_vec++; if ({done, hit, hit_nonce} !== {2'b11, 32'h42}) begin n_err++; $display("FAIL rerun_hit: got d,h=%b hn=%h want 11 42", {done, hit}, hit_nonce); end
    // abort and found together in CHECK: abort wins.
    accept(tmpl, 32'h00000007, 32'd2);
    steps(67);
    abort = 1'b1; found = 1'b1;
    step();
    abort = 1'b0; found = 1'b0;
    n_vec++; if ({done, hit, job_ready, hit_nonce} !== {3'b101, 32'h0}) begin n_err++; $display("FAIL abort_check: got d,h,r=%b hn=%h want 101 0", {done, hit, job_ready}, hit_nonce); end
  endtask

  task automatic test_back_to_back();
    accept(tmpl, 32'h00000010, 32'd2);
    for (int c = 1; c <= 137; c++) begin
      if (c == 68) begin
        n_vec++; if ({done, idle_rst} !== 2'b01) begin n_err++; $display("FAIL b2b_check1: got d,i=%b want 01", {done, idle_rst}); end
      end
      if (c == 69) begin
        n_vec++; if ({message[415:384], start, done} !== {32'h11, 2'b10}) begin n_err++; $display("FAIL b2b_second: got %h s,d=%b want 00000011 10", message[415:384], {start, done}); end
      end
      if (c == 137) begin
        n_vec++; if ({done, hit, job_ready} !== 3'b101) begin n_err++; $display("FAIL b2b_end: got d,h,r=%b want 101", {done, hit, job_ready}); end
      end
      if (c < 137) step();
    end
    accept(tmpl, 32'h00000020, 32'd1);
    n_vec++; if ({start, message[415:384]} !== {1'b1, 32'h20}) begin n_err++; $display("FAIL b2b_next: got s=%b n=%h want 1 00000020", start, message[415:384]); end
    steps(68);
    n_vec++; if ({done, hit} !== 2'b10) begin n_err++; $display("FAIL b2b_next_done: got d,h=%b want 10", {done, hit}); end
  endtask

  task automatic test_async_reset();
    int seen_done;
    accept(tmpl, 32'h00000005, 32'd2);
    steps(12);
    n_vec++; if ({round, K} !== {7'd10, 32'h243185be}) begin n_err++; $display("FAIL ares_t10: got %0d %h want 10 243185be", round, K); end
    #3 rst = 1'b1; job_valid = 1'b1;
    #1;
    n_vec++; if (ctl !== {1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 7'd0}) begin n_err++; $display("FAIL ares_ctl: got %h want %h", ctl, {1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 7'd0}); end
    n_vec++; if ({K, hit, hit_nonce} !== 65'd0 || message !== 512'd0) begin n_err++; $display("FAIL ares_data: got K=%h hit=%b hn=%h want zeros", K, hit, hit_nonce); end
    step();
    n_vec++; if ({job_ready, busy, start} !== 3'b100) begin n_err++; $display("FAIL ares_noaccept: got r,b,s=%b want 100", {job_ready, busy, start}); end
    job_valid = 1'b0; rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (done) seen_done++;
    end
    n_vec++; if (seen_done != 0) begin n_err++; $display("FAIL ares_nodone: got %0d done pulses want 0", seen_done); end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_wrap();
    test_zero_count();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
